// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the game sequencer and its switch front end.
//   state_e      : sequencer state encoding (IDLE, PLAY, END_SHOW)
//   *SHOW        : fixed 7-segment codes driven by the sequencer
//   LED_OFF      : all LEDs dark (LEDs are active-low)
//   SW_RELEASED  : switch pattern meaning "no switch pressed" / "no event"
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAY     = 2'd1,
    ST_END_SHOW = 2'd2
  } state_e;

  localparam logic [7:0] GOODSHOW    = 8'd255;
  localparam logic [7:0] ENDSHOW     = 8'd253;
  localparam logic [7:0] IDLESHOW    = 8'd252;
  localparam logic [3:0] LED_OFF     = 4'b1111;
  localparam logic [3:0] SW_RELEASED = 4'b1111;

  // Unsigned 8-bit maximum; an 8-bit result can never exceed 255, so the
  // running best score saturates naturally.
  function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Synchronizes the raw 4-bit player switches, debounces them and emits a
// one-cycle press event when the debounced value leaves the released pattern.
//   clk    : sole clock, rising edge
//   rst    : synchronous active-high reset
//   sw     : raw switches, asynchronous, 4'b1111 = released
//   change : press event, holds the new switch value for one cycle,
//            4'b1111 otherwise
// -----------------------------------------------------------------------------
module sw_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  output logic [3:0] change
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    cand_q;     // value the stability counter is timing
  logic [CW-1:0] cnt_q;      // cycles cand_q has been seen, saturating
  logic [3:0]    sw_db_q;    // debounced switch value
  logic [3:0]    db_prev_q;  // sw_db_q one cycle ago, for edge detection
  logic [3:0]    change_q;

  // NOTE: every register here is sequential state and is written with <=, so
  // all reads in this block see the pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= SW_RELEASED;
      sync2_q   <= SW_RELEASED;
      cand_q    <= SW_RELEASED;
      cnt_q     <= '0;
      sw_db_q   <= SW_RELEASED;
      db_prev_q <= SW_RELEASED;
      change_q  <= SW_RELEASED;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;

      // A new synchronized value counts as its own first stable cycle; the
      // debounced value follows once it has been seen DEBOUNCE_CYC times.
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= CW'(1);
      end else if (cnt_q >= CW'(DEBOUNCE_CYC - 1)) begin
        sw_db_q <= cand_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end

      // Only a departure from the released pattern is a press; moving
      // between two pressed patterns stays silent until release.
      db_prev_q <= sw_db_q;
      if (db_prev_q == SW_RELEASED && sw_db_q != SW_RELEASED) begin
        change_q <= sw_db_q;
      end else begin
        change_q <= SW_RELEASED;
      end
    end
  end

  assign change = change_q;

endmodule

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Top-level game flow: waits in IDLE for a start press, enables the game core
// in PLAY, then hands the display to the end-display block in END_SHOW until it
// reports done or a hold timer expires. Tracks the best level reached.
//   clk, rst                 : clock and synchronous active-high reset
//   start, sw                : raw, asynchronous start button and switches
//   adv_seg7/light/end/level : display, LEDs, end flag, level from game core
//   end_seg7/light/done      : display, LEDs, done flag from end-display block
//   play_en, end_en          : enables to game core / end-display block
//   change                   : one-cycle press event to the game core
//   seg7, lighting, best     : arbitrated display, LEDs, highest level
// All outputs are registered from the current state and inputs.
// -----------------------------------------------------------------------------
module game_sequencer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250_000,
  parameter int END_HOLD     = 75_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] sw,
  input  logic [7:0] adv_seg7,
  input  logic [3:0] adv_light,
  input  logic       adv_end,
  input  logic [7:0] adv_level,
  input  logic [7:0] end_seg7,
  input  logic [3:0] end_light,
  input  logic       end_done,
  output logic       play_en,
  output logic       end_en,
  output logic [3:0] change,
  output logic [7:0] seg7,
  output logic [3:0] lighting,
  output logic [7:0] best
);

  localparam int HW = $clog2(END_HOLD + 1);

  state_e        state_q;
  logic          start_s1_q, start_s2_q, start_prev_q;
  logic          start_rise;
  logic [HW-1:0] hold_q;
  logic [3:0]    press_event;

  logic          play_en_q, end_en_q;
  logic [3:0]    change_q, lighting_q;
  logic [7:0]    seg7_q, best_q;

  sw_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_sw_debounce (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .change (press_event)
  );

  // The edge detector keeps running in every state, so a press seen while
  // not in IDLE is consumed and never replayed later.
  assign start_rise = start_s2_q & ~start_prev_q;

  // NOTE: reset is tested first so it overrides every transition and load
  // in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      start_prev_q <= 1'b0;
      hold_q       <= '0;
      play_en_q    <= 1'b0;
      end_en_q     <= 1'b0;
      change_q     <= SW_RELEASED;
      seg7_q       <= IDLESHOW;
      lighting_q   <= LED_OFF;
      best_q       <= '0;
    end else begin
      start_s1_q   <= start;
      start_s2_q   <= start_s1_q;
      start_prev_q <= start_s2_q;

      case (state_q)
        ST_PLAY: begin
          play_en_q  <= 1'b1;
          end_en_q   <= 1'b0;
          seg7_q     <= adv_seg7;
          lighting_q <= adv_light;
          change_q   <= press_event;
          if (adv_end) begin
            state_q <= ST_END_SHOW;
            // Loaded with END_HOLD-1 so the state lasts at most END_HOLD cycles.
            hold_q  <= HW'(END_HOLD - 1);
            best_q  <= max_u8(best_q, adv_level);
          end
        end
        ST_END_SHOW: begin
          play_en_q  <= 1'b0;
          end_en_q   <= 1'b1;
          seg7_q     <= end_seg7;
          lighting_q <= end_light;
          change_q   <= SW_RELEASED;
          if (end_done || hold_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            hold_q <= hold_q - HW'(1);
          end
        end
        default: begin
          play_en_q  <= 1'b0;
          end_en_q   <= 1'b0;
          seg7_q     <= IDLESHOW;
          lighting_q <= LED_OFF;
          change_q   <= SW_RELEASED;
          state_q    <= start_rise ? ST_PLAY : ST_IDLE;
        end
      endcase
    end
  end

  assign play_en  = play_en_q;
  assign end_en   = end_en_q;
  assign change   = change_q;
  assign seg7     = seg7_q;
  assign lighting = lighting_q;
  assign best     = best_q;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
// Self-checking bench for game_sequencer with DEBOUNCE_CYC=4, END_HOLD=20.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge. Switch press events are predicted from the debounce rules applied to
// the list of (value, hold length) segments driven; game results are
// predicted from the end-of-game rules.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

  localparam int DEB  = 4;
  localparam int HOLD = 20;

  logic       clk = 1'b0;
  logic       rst, start, adv_end, end_done;
  logic [3:0] sw, adv_light, end_light;
  logic [7:0] adv_seg7, adv_level, end_seg7;
  logic       play_en, end_en;
  logic [3:0] change, lighting;
  logic [7:0] seg7, best;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] best_m = 8'd0;
  logic [3:0] pulses[$];
  logic [3:0] seg_val[$];
  int         seg_len[$];

  game_sequencer #(.DEBOUNCE_CYC(DEB), .END_HOLD(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sw        (sw),
    .adv_seg7  (adv_seg7),
    .adv_light (adv_light),
    .adv_end   (adv_end),
    .adv_level (adv_level),
    .end_seg7  (end_seg7),
    .end_light (end_light),
    .end_done  (end_done),
    .play_en   (play_en),
    .end_en    (end_en),
    .change    (change),
    .seg7      (seg7),
    .lighting  (lighting),
    .best      (best)
  );

  always #5 clk = ~clk;

  // Collect every cycle where change carries an event.
  always @(negedge clk) if (change !== 4'b1111) pulses.push_back(change);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sw = 4'b1111; adv_end = 1'b0; end_done = 1'b0;
    adv_seg7 = 8'd1; adv_light = 4'b0101; adv_level = 8'd0;
    end_seg7 = 8'd99; end_light = 4'b0011;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (play_en !== 1'b0 || end_en !== 1'b0 || change !== 4'b1111 ||
        seg7 !== 8'd252 || lighting !== 4'b1111 || best !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_values: play_en=%b end_en=%b change=%b seg7=%0d light=%b best=%0d, expected 0 0 1111 252 1111 0",
               play_en, end_en, change, seg7, lighting, best);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (seg7 !== 8'd252 || play_en !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: seg7=%0d play_en=%b, expected 252 0", seg7, play_en);
    end
  endtask

  task automatic start_game();
    int lat;
    bit seen;
    seen = 1'b0; lat = 0;
    start = 1'b1;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      if (c == 2) start = 1'b0;
      if (play_en === 1'b1) begin seen = 1'b1; lat = c; end
    end
    start = 1'b0;
    n_cmp++;
    if (!seen || lat > 4) begin
      n_bad++;
      $display("FAIL start_latency: seen=%b latency=%0d, expected play_en within 4 cycles", seen, lat);
    end
  endtask

  task automatic test_start();
    logic [7:0] s_exp;
    logic [3:0] l_exp;
    adv_seg7 = 8'd1; adv_light = 4'b0101;
    start_game();
    n_cmp++;
    if (seg7 !== 8'd1 || lighting !== 4'b0101 || end_en !== 1'b0) begin
      n_bad++;
      $display("FAIL play_entry: seg7=%0d light=%b end_en=%b, expected 1 0101 0", seg7, lighting, end_en);
    end
    for (int i = 0; i < 10; i++) begin
      s_exp = 8'($urandom); l_exp = 4'($urandom);
      adv_seg7 = s_exp; adv_light = l_exp;
      @(negedge clk);
      n_cmp++;
      if (seg7 !== s_exp || lighting !== l_exp || play_en !== 1'b1) begin
        n_bad++;
        $display("FAIL play_forward: seg7=%0d light=%b play_en=%b, expected %0d %b 1",
                 seg7, lighting, play_en, s_exp, l_exp);
      end
    end
  endtask

  // Drives the queued switch segments (plus a closing released stretch) and
  // compares the observed press events with those the debounce rules predict.
  task automatic run_segments(input string name);
    logic [3:0] db;
    logic [3:0] exp_q[$];
    seg_val.push_back(4'b1111); seg_len.push_back(12);
    db = 4'b1111;
    foreach (seg_val[i]) begin
      if (seg_len[i] >= DEB && seg_val[i] != db) begin
        if (db == 4'b1111) exp_q.push_back(seg_val[i]);
        db = seg_val[i];
      end
    end
    pulses.delete();
    foreach (seg_val[i]) begin
      sw = seg_val[i];
      repeat (seg_len[i]) @(negedge clk);
    end
    n_cmp++;
    if (pulses.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s_count: got %0d events, expected %0d", name, pulses.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (pulses[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL %s_value[%0d]: got %b, expected %b", name, i, pulses[i], exp_q[i]);
        end
      end
    end
    seg_val.delete(); seg_len.delete();
  endtask

  task automatic test_change_directed();
    seg_val = '{4'b1010, 4'b0110, 4'b1111, 4'b0110};
    seg_len = '{10, 10, 10, 10};
    run_segments("directed_change");
  endtask

  task automatic test_glitch();
    bit moved;
    moved = 1'b0;
    pulses.delete();
    sw = 4'b0000;
    repeat (2) @(negedge clk);
    sw = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dut.u_sw_debounce.sw_db_q !== 4'b1111) moved = 1'b1;
    end
    n_cmp++;
    if (moved || pulses.size() != 0) begin
      n_bad++;
      $display("FAIL glitch: sw_db_moved=%b events=%0d, expected 0 0", moved, pulses.size());
    end
  endtask

  task automatic test_change_random();
    logic [3:0] pick [6];
    logic [3:0] v, prev;
    pick = '{4'b1111, 4'b1010, 4'b0110, 4'b0000, 4'b1110, 4'b0111};
    for (int r = 0; r < 4; r++) begin
      prev = 4'b1111;
      for (int k = 0; k < 8; k++) begin
        do v = pick[$urandom_range(0, 5)]; while (v == prev);
        seg_val.push_back(v);
        seg_len.push_back(int'($urandom_range(1, 8)));
        prev = v;
      end
      if (prev == 4'b1111) begin
        seg_val.push_back(4'b0101); seg_len.push_back(6);
      end
      run_segments("random_change");
    end
  endtask

  // Ends the current game at the given level. end_done is raised so that it
  // is seen in the n-th END_SHOW cycle (n=0: never raised).
  task automatic play_game(input logic [7:0] level, input int n, input bit poke);
    int  highs, exp_highs;
    bit  done, leaked;
    highs = 0; done = 1'b0; leaked = 1'b0;
    exp_highs = (n == 0 || n > HOLD) ? HOLD : n;
    if (level > best_m) best_m = level;
    adv_level = level; adv_end = 1'b1;
    @(negedge clk);
    adv_end = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (end_en === 1'b1) begin
        highs++;
        n_cmp++;
        if (seg7 !== end_seg7 || lighting !== end_light || play_en !== 1'b0 || change !== 4'b1111) begin
          n_bad++;
          $display("FAIL end_show_outputs: seg7=%0d light=%b play_en=%b change=%b, expected %0d %b 0 1111",
                   seg7, lighting, play_en, change, end_seg7, end_light);
        end
        if (n >= 2 && highs == n - 1) end_done = 1'b1;
        if (poke && highs == 2) start = 1'b1;
        if (poke && highs == 4) start = 1'b0;
        end_seg7 = 8'($urandom); end_light = 4'($urandom);
      end else if (highs > 0) begin
        done = 1'b1;
      end
    end
    end_done = 1'b0; start = 1'b0;
    n_cmp++;
    if (!done || highs != exp_highs) begin
      n_bad++;
      $display("FAIL end_show_length: returned=%b cycles=%0d, expected 1 %0d", done, highs, exp_highs);
    end
    n_cmp++;
    if (best !== best_m) begin
      n_bad++;
      $display("FAIL best: got %0d, expected %0d", best, best_m);
    end
    n_cmp++;
    if (seg7 !== 8'd252 || lighting !== 4'b1111 || play_en !== 1'b0) begin
      n_bad++;
      $display("FAIL back_to_idle: seg7=%0d light=%b play_en=%b, expected 252 1111 0", seg7, lighting, play_en);
    end
    if (poke) begin
      repeat (10) begin
        @(negedge clk);
        if (play_en !== 1'b0 || seg7 !== 8'd252) leaked = 1'b1;
      end
      n_cmp++;
      if (leaked) begin
        n_bad++;
        $display("FAIL start_discard: game restarted after start during END_SHOW, expected to stay idle");
      end
    end
  endtask

  task automatic test_games();
    int n;
    play_game(8'd7, 0, 1'b0);
    start_game();
    play_game(8'd3, 5, 1'b1);
    start_game();
    play_game(8'd255, 20, 1'b0);
    start_game();
    play_game(8'd100, 2, 1'b0);
    for (int g = 0; g < 5; g++) begin
      n = int'($urandom_range(0, 25));
      if (n == 1) n = 2;
      start_game();
      play_game(8'($urandom), n, 1'b0);
    end
  endtask

  task automatic test_reset_mid_play();
    bit leaked;
    leaked = 1'b0;
    start_game();
    pulses.delete();
    sw = 4'b1010;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    best_m = 8'd0;
    @(negedge clk);
    n_cmp++;
    if (play_en !== 1'b0 || end_en !== 1'b0 || change !== 4'b1111 ||
        seg7 !== 8'd252 || lighting !== 4'b1111 || best !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_mid_play: play_en=%b end_en=%b change=%b seg7=%0d light=%b best=%0d, expected 0 0 1111 252 1111 0",
               play_en, end_en, change, seg7, lighting, best);
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (play_en !== 1'b0) leaked = 1'b1;
    end
    sw = 4'b1111;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (pulses.size() != 0 || leaked) begin
      n_bad++;
      $display("FAIL reset_no_event: events=%0d restarted=%b, expected 0 0", pulses.size(), leaked);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_change_directed();
    test_glitch();
    test_change_random();
    test_games();
    test_reset_mid_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
